conv_pe_sequencer: RTL and testbench

//  Sequences the 16-PE 3x3 conv array: per OFM pixel, a 1-cycle PE_en launch, TILE_CYCLES-2 accumulate cycles, then a 1-cycle PE_finish.

---
 rtl/conv_pe_sequencer_if.sv | 48 ++++
 rtl/conv_pe_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_conv_pe_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/conv_pe_sequencer_if.sv
// Handshake/bus bundle between the conv PE sequencer and its surroundings
// (host control, PE array, OFM writer).
//   master : the sequencer side (drives PE_en/PE_finish, coordinates, write strobe, status)
//   slave  : host / PE-array side (drives start, abort, valid)
// Signals:
//   start, abort         host control pulses
//   PE_en, PE_finish     per-PE launch / finish pulses (NUM_PE wide)
//   valid                per-PE result-valid flags (NUM_PE wide)
//   cur_row/col/pass     OFM coordinate of the pixel being computed
//   ofm_wr_en, ofm_addr  OFM write strobe and linear result index
//   busy, done, err      status
interface conv_pe_sequencer_if #(
  parameter int NUM_PE     = 16,
  parameter int OFM_W      = 56,
  parameter int OFM_H      = 56,
  parameter int NUM_PASSES = 2,
  parameter int ADDR_W     = 16
);
  localparam int ROW_W  = (OFM_H > 1) ? $clog2(OFM_H) : 1;
  localparam int COL_W  = (OFM_W > 1) ? $clog2(OFM_W) : 1;
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  logic              start;
  logic              abort;
  logic [NUM_PE-1:0] PE_en;
  logic [NUM_PE-1:0] PE_finish;
  logic [NUM_PE-1:0] valid;
  logic [ROW_W-1:0]  cur_row;
  logic [COL_W-1:0]  cur_col;
  logic [PASS_W-1:0] cur_pass;
  logic              ofm_wr_en;
  logic [ADDR_W-1:0] ofm_addr;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, abort, valid,
    output PE_en, PE_finish, cur_row, cur_col, cur_pass,
           ofm_wr_en, ofm_addr, busy, done, err
  );

  modport slave (
    output start, abort, valid,
    input  PE_en, PE_finish, cur_row, cur_col, cur_pass,
           ofm_wr_en, ofm_addr, busy, done, err
  );
endinterface

// File: rtl/conv_pe_sequencer.sv
// conv_pe_sequencer
// Drives the 16-PE 3x3 conv array. For every OFM pixel it issues a 1-cycle
// PE_en launch, holds TILE_CYCLES-2 accumulate cycles, then a 1-cycle
// PE_finish, so each pixel takes exactly TILE_CYCLES cycles. Pixels are
// scanned col -> row -> pass. PE results are collected independently of the
// launch schedule: an all-valid beat writes one OFM result at the linear
// index res_cnt; a partial-valid beat, or a beat beyond the last result,
// flags err.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high
//   bus    conv_pe_sequencer_if.master (start/abort/valid in; PE_en,
//          PE_finish, cur_row/col/pass, ofm_wr_en, ofm_addr, busy, done, err out)
// Configuration:
//   CONV_SEQ_WDOG_EN  when defined, a watchdog limits the DRAIN wait to
//                     DRAIN_TIMEOUT cycles; on expiry err is set and the
//                     layer completes through DONE. Undefined: DRAIN waits
//                     for the last result indefinitely.
module conv_pe_sequencer #(
  parameter int NUM_PE        = 16,
  parameter int OFM_W         = 56,
  parameter int OFM_H         = 56,
  parameter int NUM_PASSES    = 2,
  parameter int TILE_CYCLES   = 36,
  parameter int ADDR_W        = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input logic                 clk,
  input logic                 reset,
  conv_pe_sequencer_if.master bus
);
  localparam int TOTAL  = OFM_W * OFM_H * NUM_PASSES;
  localparam int ROW_W  = (OFM_H > 1) ? $clog2(OFM_H) : 1;
  localparam int COL_W  = (OFM_W > 1) ? $clog2(OFM_W) : 1;
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int ACC_W  = $clog2(TILE_CYCLES);
  localparam int RES_W  = $clog2(TOTAL + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ACCUM,
    S_FINISH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [PASS_W-1:0] r_pass;
  logic [ACC_W-1:0]  r_acc_cnt;
  logic [RES_W-1:0]  r_res_cnt;
  logic [RES_W-1:0]  w_res_nxt;
  logic              r_err;

  logic w_pe_en;
  logic w_pe_fin;
  logic w_busy;
  logic w_done;
  logic w_wdog_exp;
  logic w_active;
  logic w_all_vld;
  logic w_any_vld;
  logic w_full;
  logic w_wr_en;
  logic w_err_set;
  logic w_last_pix;
  logic w_start_acc;

`ifdef CONV_SEQ_WDOG_EN
  localparam int DRN_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  logic [DRN_W-1:0] r_drain_cnt;
`else
  // Timeout only matters with the watchdog compiled in.
  logic w_unused_cfg;
  assign w_unused_cfg = (DRAIN_TIMEOUT > 0);
`endif

  // Result path: live in every state except IDLE.
  assign w_active  = (r_state != S_IDLE);
  assign w_all_vld = &bus.valid;
  assign w_any_vld = |bus.valid;
  assign w_full    = (r_res_cnt == RES_W'(TOTAL));
  assign w_wr_en   = w_active && w_all_vld && !w_full;
  assign w_err_set = (w_active && w_any_vld && !w_all_vld) ||
                     (w_active && w_all_vld && w_full) ||
                     w_wdog_exp;
  // DRAIN looks at the post-write count so DONE follows the final write by one cycle.
  assign w_res_nxt = w_wr_en ? (r_res_cnt + RES_W'(1)) : r_res_cnt;

  assign w_last_pix  = (r_col == COL_W'(OFM_W - 1)) &&
                       (r_row == ROW_W'(OFM_H - 1)) &&
                       (r_pass == PASS_W'(NUM_PASSES - 1));
  assign w_start_acc = (r_state == S_IDLE) && bus.start && !bus.abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pe_en     = 1'b0;
    w_pe_fin    = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_wdog_exp  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_pe_en     = 1'b1;
        w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        if (r_acc_cnt == ACC_W'(TILE_CYCLES - 3)) w_state_nxt = S_FINISH;
      end
      S_FINISH: begin
        w_pe_fin    = 1'b1;
        w_state_nxt = w_last_pix ? S_DRAIN : S_LAUNCH;
      end
      S_DRAIN: begin
        if (w_res_nxt == RES_W'(TOTAL)) begin
          w_state_nxt = S_DONE;
        end
`ifdef CONV_SEQ_WDOG_EN
        else if (r_drain_cnt == DRN_W'(DRAIN_TIMEOUT - 1)) begin
          w_state_nxt = S_DONE;
          w_wdog_exp  = !bus.abort;
        end
`endif
      end
      S_DONE: begin
        w_busy      = 1'b0;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // abort overrides every transition, including a start in IDLE.
    if (bus.abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row     <= '0;
      r_col     <= '0;
      r_pass    <= '0;
      r_acc_cnt <= '0;
      r_res_cnt <= '0;
      r_err     <= 1'b0;
    end else if (bus.abort) begin
      r_row     <= '0;
      r_col     <= '0;
      r_pass    <= '0;
      r_acc_cnt <= '0;
      r_res_cnt <= '0;
    end else begin
      if (w_start_acc) begin
        r_row     <= '0;
        r_col     <= '0;
        r_pass    <= '0;
        r_res_cnt <= '0;
        r_err     <= 1'b0;
      end else begin
        if (w_wr_en)   r_res_cnt <= w_res_nxt;
        if (w_err_set) r_err     <= 1'b1;
      end
      if (r_state == S_LAUNCH) r_acc_cnt <= '0;
      if (r_state == S_ACCUM)  r_acc_cnt <= r_acc_cnt + ACC_W'(1);
      // Coordinates advance on FINISH so they stay put from LAUNCH to FINISH.
      if (r_state == S_FINISH) begin
        if (r_col == COL_W'(OFM_W - 1)) begin
          r_col <= '0;
          if (r_row == ROW_W'(OFM_H - 1)) begin
            r_row <= '0;
            if (r_pass == PASS_W'(NUM_PASSES - 1)) r_pass <= '0;
            else                                   r_pass <= r_pass + PASS_W'(1);
          end else begin
            r_row <= r_row + ROW_W'(1);
          end
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

`ifdef CONV_SEQ_WDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_drain_cnt <= '0;
    else if (r_state == S_DRAIN && !bus.abort) r_drain_cnt <= r_drain_cnt + DRN_W'(1);
    else                           r_drain_cnt <= '0;
  end
`endif

  assign bus.PE_en     = {NUM_PE{w_pe_en}};
  assign bus.PE_finish = {NUM_PE{w_pe_fin}};
  assign bus.cur_row   = r_row;
  assign bus.cur_col   = r_col;
  assign bus.cur_pass  = r_pass;
  assign bus.ofm_wr_en = w_wr_en;
  assign bus.ofm_addr  = ADDR_W'(r_res_cnt);
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_conv_pe_sequencer.sv
module tb_conv_pe_sequencer;
  logic clk;
  logic reset;

  conv_pe_sequencer_if #(
    .NUM_PE(16), .OFM_W(2), .OFM_H(2), .NUM_PASSES(1), .ADDR_W(16)
  ) bus ();

  conv_pe_sequencer #(
    .NUM_PE(16), .OFM_W(2), .OFM_H(2), .NUM_PASSES(1),
    .TILE_CYCLES(4), .ADDR_W(16), .DRAIN_TIMEOUT(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int t;
  int en_t[$];
  int fin_t[$];
  int rc_log[$];
  int wr_t[$];
  int wr_a[$];
  int done_t[$];
  int busy_log[$];
  int en_bad;
  int err_t1;
  int last_err;
  int last_busy;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Drive one cycle's inputs, sample 1 time unit later, then advance past the next edge.
  task automatic step(input logic s, input logic a, input logic [15:0] v);
    bus.start = s;
    bus.abort = a;
    bus.valid = v;
    #1;
    if (bus.PE_en != 16'h0) begin
      en_t.push_back(t);
      rc_log.push_back(int'(bus.cur_row) * 2 + int'(bus.cur_col));
      if (bus.PE_en != 16'hFFFF) en_bad++;
    end
    if (bus.PE_finish != 16'h0) begin
      fin_t.push_back(t);
      if (bus.PE_finish != 16'hFFFF) en_bad++;
    end
    if (bus.ofm_wr_en) begin
      wr_t.push_back(t);
      wr_a.push_back(int'(bus.ofm_addr));
    end
    if (bus.done) done_t.push_back(t);
    if (t == 1) err_t1 = int'(bus.err);
    busy_log.push_back(int'(bus.busy));
    last_err  = int'(bus.err);
    last_busy = int'(bus.busy);
    @(posedge clk);
    #1;
    t++;
  endtask

  // One layer run from t=0 (start). PE model: all-valid 2 cycles after each
  // PE_finish, for the first nvalid finishes only.
  task automatic run_layer(input int bad_t, input int xstart_t, input int abort_t,
                           input int nvalid, input int ncyc);
    en_t.delete(); fin_t.delete(); rc_log.delete(); wr_t.delete();
    wr_a.delete(); done_t.delete(); busy_log.delete();
    en_bad = 0; err_t1 = -1; t = 0;
    for (int c = 0; c < ncyc; c++) begin
      logic [15:0] v;
      logic        s;
      logic        a;
      s = (c == 0) || (c == xstart_t);
      a = (c == abort_t);
      v = 16'h0;
      if (fin_t.size() > 0 && fin_t.size() <= nvalid && fin_t[fin_t.size()-1] == c - 2)
        v = 16'hFFFF;
      if (c == bad_t) v = 16'h00FF;
      step(s, a, v);
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.valid = 16'h0;
  endtask

  task automatic check_layer(input string tag, input int exp_err);
    chk({tag, ".n_en"},   en_t.size(),   4);
    chk({tag, ".n_fin"},  fin_t.size(),  4);
    chk({tag, ".n_wr"},   wr_t.size(),   4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s.en_t[%0d]", tag, i),  (i < en_t.size())   ? en_t[i]   : -1, 1 + 4*i);
      chk($sformatf("%s.fin_t[%0d]", tag, i), (i < fin_t.size())  ? fin_t[i]  : -1, 4 + 4*i);
      chk($sformatf("%s.rc[%0d]", tag, i),    (i < rc_log.size()) ? rc_log[i] : -1, i);
      chk($sformatf("%s.wr_t[%0d]", tag, i),  (i < wr_t.size())   ? wr_t[i]   : -1, 6 + 4*i);
      chk($sformatf("%s.addr[%0d]", tag, i),  (i < wr_a.size())   ? wr_a[i]   : -1, i);
    end
    chk({tag, ".n_done"}, done_t.size(), 1);
    chk({tag, ".done_t"}, (done_t.size() > 0) ? done_t[0] : -1, 19);
    chk({tag, ".err"},    last_err,  exp_err);
    chk({tag, ".busy"},   last_busy, 0);
    chk({tag, ".en_all"}, en_bad,    0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.valid = 16'h0;
    t = 0; en_bad = 0;
    #2;
    chk("rst.pe_en",  int'(bus.PE_en),     0);
    chk("rst.pe_fin", int'(bus.PE_finish), 0);
    chk("rst.busy",   int'(bus.busy),      0);
    chk("rst.done",   int'(bus.done),      0);
    chk("rst.err",    int'(bus.err),       0);
    chk("rst.wr",     int'(bus.ofm_wr_en), 0);
    chk("rst.addr",   int'(bus.ofm_addr),  0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset mid-ACCUM of the 2nd pixel, with err already set.
    t = 0;
    step(1'b1, 1'b0, 16'h0);     // t=0 start
    step(1'b0, 1'b0, 16'h0);     // t=1 LAUNCH
    step(1'b0, 1'b0, 16'h00FF);  // t=2 partial valid -> err
    step(1'b0, 1'b0, 16'h0);     // t=3
    step(1'b0, 1'b0, 16'h0);     // t=4 FINISH
    step(1'b0, 1'b0, 16'h0);     // t=5 LAUNCH
    step(1'b0, 1'b0, 16'hFFFF);  // t=6 write 0
    bus.valid = 16'h0;
    #1;
    chk("mid.busy", int'(bus.busy),    1);
    chk("mid.col",  int'(bus.cur_col), 1);
    chk("mid.err",  int'(bus.err),     1);
    chk("mid.addr", int'(bus.ofm_addr), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst.busy",  int'(bus.busy),     0);
    chk("arst.col",   int'(bus.cur_col),  0);
    chk("arst.err",   int'(bus.err),      0);
    chk("arst.addr",  int'(bus.ofm_addr), 0);
    chk("arst.pe_en", int'(bus.PE_en),    0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Normal layer.
    run_layer(-1, -1, -1, 4, 22);
    check_layer("norm", 0);

    // Partial-valid beat: err sticks through DONE into IDLE, no extra write.
    run_layer(3, -1, -1, 4, 22);
    check_layer("part", 1);

    // Abort during 3rd ACCUM; start clears err.
    run_layer(-1, -1, 10, 4, 18);
    chk("abt.err_cleared", err_t1, 0);
    chk("abt.n_en",   en_t.size(), 3);
    chk("abt.busy11", (busy_log.size() > 11) ? busy_log[11] : -1, 0);
    chk("abt.n_done", done_t.size(), 0);
    chk("abt.err",    last_err, 0);

    // Restart after abort.
    run_layer(-1, -1, -1, 4, 22);
    check_layer("rstrt", 0);

    // start pulsed mid-run is ignored.
    run_layer(-1, 7, -1, 4, 22);
    check_layer("ign", 0);

    // Last result never arrives.
    run_layer(-1, -1, -1, 3, 30);
    chk("wd.n_wr", wr_t.size(), 3);
`ifdef CONV_SEQ_WDOG_EN
    chk("wd.n_done", done_t.size(), 1);
    chk("wd.done_t", (done_t.size() > 0) ? done_t[0] : -1, 25);
    chk("wd.busy24", (busy_log.size() > 24) ? busy_log[24] : -1, 1);
    chk("wd.err",    last_err,  1);
    chk("wd.busy",   last_busy, 0);
`else
    chk("wd.n_done", done_t.size(), 0);
    chk("wd.busy",   last_busy, 1);
    chk("wd.err",    last_err,  0);
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    chk("wd.abort_busy", last_busy, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
